// File: rtl/jtag_led_arbiter.sv
// Single-owner LED bank arbiter: JTAG writes pre-empt and lock out local requesters,
// which are served round-robin (or fixed priority with LEDARB_FIXED_PRIO_EN) with a hold time.
module jtag_led_arbiter #(
    parameter int NREQ             = 4,
    parameter int W                = 8,
    parameter int HOLD_CYCLES      = 16,
    parameter int JTAG_LOCK_CYCLES = 256
) (
    input  logic              tck,
    input  logic              aclr,
    input  logic              jtag_wr,
    input  logic [W-1:0]      jtag_data,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      leds,
    output logic              busy,
    output logic              jtag_locked
);
    localparam int MAXC = (HOLD_CYCLES > JTAG_LOCK_CYCLES) ? HOLD_CYCLES : JTAG_LOCK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] LOCK_LOAD = CW'(JTAG_LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD, LOCK} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [W-1:0]    leds_d;
    logic [NREQ-1:0] gnt_d;
    logic [IW-1:0]   win;
    logic            found;
`ifndef LEDARB_FIXED_PRIO_EN
    logic [IW-1:0]   rr, rr_d;
`endif

    // Winner selection among currently asserted requests.
    always_comb begin : arb
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
`ifdef LEDARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
`endif
    end

    always_ff @(posedge tck) begin
        if (aclr) begin
            state <= IDLE;
            cnt   <= '0;
            leds  <= '0;
            gnt   <= '0;
`ifndef LEDARB_FIXED_PRIO_EN
            rr    <= '0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            leds  <= leds_d;
            gnt   <= gnt_d;
`ifndef LEDARB_FIXED_PRIO_EN
            rr    <= rr_d;
`endif
        end
    end

    // A JTAG write wins from every state, including a reload while already locked.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        leds_d  = leds;
        gnt_d   = '0;
`ifndef LEDARB_FIXED_PRIO_EN
        rr_d    = rr;
`endif
        if (jtag_wr) begin
            state_d = LOCK;
            cnt_d   = LOCK_LOAD;
            leds_d  = jtag_data;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state_d = GRANT;
                        gnt_d   = NREQ'(1) << win;
                        leds_d  = req_data[win*W +: W];
`ifndef LEDARB_FIXED_PRIO_EN
                        rr_d    = IW'((int'(win) + 1) % NREQ);
`endif
                    end
                end
                GRANT: begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                HOLD, LOCK: begin
                    if (cnt == '0) state_d = IDLE;
                    else           cnt_d   = cnt - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        jtag_locked = (state == LOCK);
    end
endmodule

// File: tb/tb_jtag_led_arbiter.sv
// Bench for jtag_led_arbiter: directed scenarios then randomized traffic against a
// timing-window reference model (earliest-next-grant / lock-expiry edge numbers).
module tb_jtag_led_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int HOLD = 16;
    localparam int LOCK = 256;

    logic              tck = 1'b0;
    logic              aclr;
    logic              jtag_wr;
    logic [W-1:0]      jtag_data;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      leds;
    logic              busy;
    logic              jtag_locked;

    jtag_led_arbiter #(.NREQ(NREQ), .W(W), .HOLD_CYCLES(HOLD), .JTAG_LOCK_CYCLES(LOCK)) dut (
        .tck(tck), .aclr(aclr), .jtag_wr(jtag_wr), .jtag_data(jtag_data),
        .req(req), .req_data(req_data), .gnt(gnt), .leds(leds),
        .busy(busy), .jtag_locked(jtag_locked)
    );

    always #5 tck = ~tck;

    // Model: n = edge number; windows are expressed as absolute edge numbers.
    int n = 0;
    int free_at = 0, busy_until = 0, lock_until = 0, last = NREQ - 1;
    logic [W-1:0]    m_leds = '0;
    logic [NREQ-1:0] m_gnt  = '0;
    int total = 0, passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, n);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef LEDARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic tick();
        int w;
        @(posedge tck);
        n++;
        if (aclr) begin
            m_leds = '0; m_gnt = '0; last = NREQ - 1;
            free_at = n + 1; busy_until = n; lock_until = n;
        end else if (jtag_wr) begin
            m_leds = jtag_data; m_gnt = '0;
            busy_until = n + LOCK; lock_until = n + LOCK; free_at = n + LOCK + 1;
        end else begin
            w = pick(req);
            if (n >= free_at && w >= 0) begin
                m_gnt = NREQ'(1) << w; m_leds = req_data[w*W +: W]; last = w;
                busy_until = n + HOLD + 1; free_at = n + HOLD + 2;
            end else m_gnt = '0;
        end
        #1;
        check("leds", 32'(leds), 32'(m_leds));
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("busy", 32'(busy), 32'(n < busy_until));
        check("jtag_locked", 32'(jtag_locked), 32'(n < lock_until));
    endtask

    task automatic wait_gnt(input int bound, output int waited);
        waited = 0;
        do begin tick(); waited++; end while (gnt == '0 && waited < bound);
        check("wait_gnt_seen", 32'(|gnt), 32'd1);
    endtask

    int gt[$];
    logic [NREQ-1:0] gi[$];
    int w, n0;
    logic [NREQ-1:0] exp_a, exp_b;

    initial begin
        // Reset with random inputs on the other pins
        aclr = 1'b1; jtag_wr = 1'($urandom); jtag_data = W'($urandom);
        req = NREQ'($urandom); req_data = {$urandom, $urandom};
        tick(); tick();
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        aclr = 1'b0; jtag_wr = 1'b0;

        // Round-robin between requesters 0 and 2
        req = 4'b0101; req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 80; i++) begin
            tick();
            if (gnt != '0) begin gt.push_back(n); gi.push_back(gnt); end
        end
        check("rr_count", 32'(gt.size() >= 4), 32'd1);
`ifdef LEDARB_FIXED_PRIO_EN
        exp_a = 4'b0001; exp_b = 4'b0001;
`else
        exp_a = 4'b0001; exp_b = 4'b0100;
`endif
        if (gt.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", 32'(gi[i]), 32'((i % 2 == 0) ? exp_a : exp_b));
            for (int i = 0; i < 3; i++) check("rr_spacing", 32'(gt[i+1] - gt[i]), 32'd18);
        end

        // JTAG pre-empts during HOLD
        jtag_wr = 1'b1; jtag_data = 8'hA5; tick(); jtag_wr = 1'b0;
        check("preempt_leds", 32'(leds), 32'hA5);
        check("preempt_locked", 32'(jtag_locked), 32'd1);
        req = 4'b0010; req_data[15:8] = 8'h77;
        wait_gnt(400, w);
        check("preempt_wait", 32'(w), 32'd257);
        check("preempt_gnt", 32'(gnt), 32'b0010);
        check("preempt_data", 32'(leds), 32'h77);
        req = '0;

        // Collision in IDLE: JTAG wins
        aclr = 1'b1; tick(); aclr = 1'b0;
        req = 4'b1000; req_data[31:24] = 8'h99; jtag_wr = 1'b1; jtag_data = 8'h5A; tick(); jtag_wr = 1'b0;
        check("coll_leds", 32'(leds), 32'h5A);
        check("coll_gnt", 32'(gnt), 32'h0);
        wait_gnt(400, w);
        check("coll_wait", 32'(w), 32'd257);
        check("coll_gnt3", 32'(gnt), 32'b1000);
        req = '0;

        // Lock reload at relative cycle 200
        aclr = 1'b1; tick(); aclr = 1'b0;
        jtag_wr = 1'b1; jtag_data = 8'h3C; tick(); n0 = n; jtag_wr = 1'b0;
        for (int i = 0; i < 199; i++) tick();
        jtag_wr = 1'b1; jtag_data = 8'hC3; tick(); jtag_wr = 1'b0;
        for (int i = 0; i < 600 && jtag_locked; i++) tick();
        check("reload_end", 32'(n - n0), 32'd456);
        check("reload_leds", 32'(leds), 32'hC3);

        // Reset mid-HOLD
        req = 4'b0001;
        wait_gnt(100, w);
        for (int i = 0; i < 5; i++) tick();
        check("midhold_busy", 32'(busy), 32'd1);
        aclr = 1'b1; tick(); aclr = 1'b0;
        check("midhold_rst_busy", 32'(busy), 32'd0);
        check("midhold_rst_leds", 32'(leds), 32'h0);
        req = '0;

        // Randomized traffic: requests held until granted, occasionally dropped
        for (int c = 0; c < 4000; c++) begin
            aclr      = ($urandom % 400) == 0;
            jtag_wr   = ($urandom % 350) == 0;
            jtag_data = W'($urandom);
            if (($urandom % 8) == 0) req_data = {$urandom, $urandom};
            req = (req & ~gnt) | (NREQ'($urandom) & NREQ'($urandom));
            if (($urandom % 20) == 0) req = req & NREQ'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
